// File: rtl/dmem_responder.sv
// Data-memory responder: one request in flight, fixed programmable latency, byte-lane
// masked stores, full-word loads, pattern/alignment and range checking.
module dmem_responder #(
    parameter int XLEN       = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [3:0]      req_amp_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam bit             DIRECT   = (LATENCY == 1);
    localparam logic [3:0]     CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam int             DEPTH    = 1 << DEPTH_LOG2;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q;
    logic [XLEN-1:0]   addr_q, wdata_q;
    logic [3:0]        amp_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [XLEN-1:0]   mem [DEPTH];

    logic              accept;
    logic              do_access;
    logic              acc_we;
    logic [XLEN-1:0]   acc_addr, acc_wdata;
    logic [3:0]        acc_amp;
    logic              amp_ok, range_err, acc_err;
    logic [DEPTH_LOG2-1:0] idx;
    logic              mem_we;

    assign req_ready_o  = (state_q != BUSY);
    assign resp_valid_o = (state_q == RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign accept       = req_valid_i & req_ready_o;

    // With single-cycle latency the access happens on the accept edge itself,
    // so the live request is used instead of the latched copy.
    assign acc_we    = DIRECT ? req_we_i    : we_q;
    assign acc_addr  = DIRECT ? req_addr_i  : addr_q;
    assign acc_wdata = DIRECT ? req_wdata_i : wdata_q;
    assign acc_amp   = DIRECT ? req_amp_i   : amp_q;
    assign idx       = acc_addr[DEPTH_LOG2+1:2];

    always_comb begin
        amp_ok = 1'b0;
        case (acc_amp)
            4'b1111, 4'b0011: amp_ok = (acc_addr[1:0] == 2'b00);
            4'b1100:          amp_ok = (acc_addr[1:0] == 2'b10);
            4'b0001:          amp_ok = (acc_addr[1:0] == 2'b00);
            4'b0010:          amp_ok = (acc_addr[1:0] == 2'b01);
            4'b0100:          amp_ok = (acc_addr[1:0] == 2'b10);
            4'b1000:          amp_ok = (acc_addr[1:0] == 2'b11);
            default:          amp_ok = 1'b0;
        endcase
    end

    assign range_err = |acc_addr[XLEN-1:DEPTH_LOG2+2];
    assign acc_err   = range_err | ~amp_ok;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        do_access = 1'b0;
        rdata_d   = '0;
        err_d     = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (DIRECT) begin
                        state_d   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d   = RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_access) begin
            err_d   = acc_err;
            rdata_d = (!acc_err && !acc_we) ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            amp_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                we_q    <= req_we_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                amp_q   <= req_amp_i;
            end
        end
    end

    // Reset gates the write so an interrupted request never lands in the array.
    assign mem_we = do_access & acc_we & ~acc_err & ~reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_amp[i]) mem[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 2, 1 and 4 (three instances).
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset      [3];
    logic        req_valid  [3];
    logic        req_ready  [3];
    logic        req_we     [3];
    logic [31:0] req_addr   [3];
    logic [31:0] req_wdata  [3];
    logic [3:0]  req_amp    [3];
    logic        resp_valid [3];
    logic [31:0] resp_rdata [3];
    logic        resp_err   [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .LATENCY(2)) u_l2 (
        .clk(clk), .reset(reset[0]),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_we_i(req_we[0]),
        .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]), .req_amp_i(req_amp[0]),
        .resp_valid_o(resp_valid[0]), .resp_rdata_o(resp_rdata[0]), .resp_err_o(resp_err[0]));

    dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
        .clk(clk), .reset(reset[1]),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_we_i(req_we[1]),
        .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]), .req_amp_i(req_amp[1]),
        .resp_valid_o(resp_valid[1]), .resp_rdata_o(resp_rdata[1]), .resp_err_o(resp_err[1]));

    dmem_responder #(.XLEN(32), .DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
        .clk(clk), .reset(reset[2]),
        .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]), .req_we_i(req_we[2]),
        .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]), .req_amp_i(req_amp[2]),
        .resp_valid_o(resp_valid[2]), .resp_rdata_o(resp_rdata[2]), .resp_err_o(resp_err[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge, then measure latency and check the response.
    task automatic do_req(input int s, input int lat, input logic we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] amp,
                          input logic [31:0] exp_rd, input logic exp_err, input string tag);
        int n;
        req_valid[s] = 1'b1; req_we[s] = we; req_addr[s] = a;
        req_wdata[s] = wd;   req_amp[s] = amp;
        @(posedge clk);
        @(negedge clk);
        req_valid[s] = 1'b0;
        n = 1;
        while (!resp_valid[s] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".rdata"}, resp_rdata[s], exp_rd);
        chk({tag, ".err"}, {31'd0, resp_err[s]}, {31'd0, exp_err});
        @(negedge clk);
        chk({tag, ".pulse"}, {31'd0, resp_valid[s]}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
            req_addr[i] = '0; req_wdata[i] = '0; req_amp[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("rst.rdata", resp_rdata[0], 32'd0);
        chk("rst.err",   {31'd0, resp_err[0]}, 32'd0);
        chk("rst.ready", {31'd0, req_ready[0]}, 32'd1);
        for (int i = 0; i < 3; i++) reset[i] = 1'b0;
        @(negedge clk);

        // LATENCY 2: full word, lane merges, illegal patterns, out of range
        do_req(0, 2, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, "st_full");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, "ld_full");
        do_req(0, 2, 1'b1, 32'h12, 32'h00550000, 4'b0100, 32'h0, 1'b0, "st_b2");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE55BEEF, 1'b0, "ld_b2");
        do_req(0, 2, 1'b1, 32'h10, 32'h0000AAAA, 4'b0011, 32'h0, 1'b0, "st_h0");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE55AAAA, 1'b0, "ld_h0");
        do_req(0, 2, 1'b1, 32'h11, 32'hFFFFFFFF, 4'b0011, 32'h0, 1'b1, "st_mis");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'hDE55AAAA, 1'b0, "ld_mis");
        do_req(0, 2, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0101, 32'h0, 1'b1, "st_0101");
        do_req(0, 2, 1'b1, 32'h12, 32'h11000000, 4'b1000, 32'h0, 1'b1, "st_b3bad");
        do_req(0, 2, 1'b1, 32'h13, 32'h77000000, 4'b1000, 32'h0, 1'b0, "st_b3");
        do_req(0, 2, 1'b1, 32'h12, 32'h99880000, 4'b1100, 32'h0, 1'b0, "st_h1");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h9988AAAA, 1'b0, "ld_h1");
        do_req(0, 2, 1'b0, 32'h1000, 32'h0, 4'b1111, 32'h0, 1'b1, "ld_oor");
        do_req(0, 2, 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 32'h0, 1'b0, "st_top");
        do_req(0, 2, 1'b0, 32'hFFC, 32'h0, 4'b1111, 32'hCAFEF00D, 1'b0, "ld_top");
        do_req(0, 2, 1'b1, 32'h80000010, 32'h12345678, 4'b1111, 32'h0, 1'b1, "st_oor");
        do_req(0, 2, 1'b0, 32'h10, 32'h0, 4'b1111, 32'h9988AAAA, 1'b0, "ld_oor2");

        // LATENCY 1: back-to-back stores with valid held high
        req_valid[1] = 1'b1; req_we[1] = 1'b1; req_amp[1] = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            req_addr[1]  = 32'(k * 4);
            req_wdata[1] = 32'hA0000000 + 32'(k);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b2b.ready%0d", k), {31'd0, req_ready[1]}, 32'd1);
            chk($sformatf("b2b.valid%0d", k), {31'd0, resp_valid[1]}, 32'd1);
        end
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("b2b.idle", {31'd0, resp_valid[1]}, 32'd0);
        do_req(1, 1, 1'b0, 32'h0, 32'h0, 4'b1111, 32'hA0000000, 1'b0, "l1_ld0");
        do_req(1, 1, 1'b0, 32'h4, 32'h0, 4'b1111, 32'hA0000001, 1'b0, "l1_ld4");
        do_req(1, 1, 1'b0, 32'h8, 32'h0, 4'b1111, 32'hA0000002, 1'b0, "l1_ld8");

        // LATENCY 4: initialize, then reset in the middle of a store
        do_req(2, 4, 1'b1, 32'h20, 32'h0, 4'b1111, 32'h0, 1'b0, "l4_init");
        do_req(2, 4, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h0, 1'b0, "l4_ld0");
        req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h20;
        req_wdata[2] = 32'h12345678; req_amp[2] = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset[2] = 1'b1;
        #1;
        chk("mid.valid", {31'd0, resp_valid[2]}, 32'd0);
        chk("mid.rdata", resp_rdata[2], 32'd0);
        chk("mid.err",   {31'd0, resp_err[2]}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("mid.hold%0d", k), {31'd0, resp_valid[2]}, 32'd0);
        end
        reset[2] = 1'b0;
        @(negedge clk);
        chk("mid.ready", {31'd0, req_ready[2]}, 32'd1);
        do_req(2, 4, 1'b0, 32'h20, 32'h0, 4'b1111, 32'h0, 1'b0, "l4_after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder at the far end of the pipeline's load/store port. It accepts one request at a time from the memory stage: address, write enable, lane-positioned write data and a 4-bit access-memory pattern (byte-lane enables). After a programmable latency it performs a byte-lane-masked write or a full-word read and returns a single-cycle response. It also checks that the pattern is legal and consistent with the address, and that the address is in range. Load-side lane extraction and sign-extension stay in the CPU; this block returns the raw 32-bit word.

Parameters:
XLEN, 32, data/address width
DEPTH_LOG2, 10, log2 of memory depth in words (1024 words = 4 KiB)
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  XLEN  byte address
req_wdata  input  XLEN  store data, already placed in its byte lanes
req_amp  input  4  byte-lane pattern; bit i enables bits [8i+7:8i]
resp_valid  output  1  response pulse, one cycle
resp_rdata  output  XLEN  read word; 0 for stores and errors
resp_err  output  1  request rejected; valid only with resp_valid

Behaviour:
- Reset is asynchronous, active-high on reset; clock is clk. During and after reset: FSM=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0. Memory array contents are not reset.
- FSM states:
  - IDLE, BUSY, RESP.
  - req_ready = 1 in IDLE and RESP, 0 in BUSY (combinational from state).
- Accept: a request is taken at a rising edge where req_valid & req_ready. At that edge, latch we/addr/wdata/amp.
  - If LATENCY == 1, go to RESP.
  - Otherwise load the counter with LATENCY-2 and go to BUSY.
- BUSY: counter decrements each cycle. At the edge where the counter is 0, perform the access and go to RESP.
- Access edge: the memory write (or the read capture into resp_rdata) happens on the same edge that enters RESP.
- Latency guarantee: a request accepted at edge t gives resp_valid=1 in exactly the cycle after edge t+LATENCY-1, i.e. LATENCY cycles later, for exactly one cycle.
- RESP: resp_valid=1 for this one cycle.
  - If req_valid, a new request is accepted at the next edge; back-to-back throughput is one request per LATENCY cycles.
  - Otherwise go to IDLE, and resp_valid, resp_rdata and resp_err return to 0.
- Word index = addr[DEPTH_LOG2+1:2].
- Stores write only the lanes whose amp bit is 1; other lanes keep their value. resp_rdata = 0.
- Loads return the full stored word at the index, regardless of amp.
- Legal amp/addr pairs: 1111 with addr[1:0]=00; 0011 with addr[1:0]=00; 1100 with addr[1:0]=10; 0001/0010/0100/1000 with addr[1:0]=00/01/10/11 respectively. Any other amp, or any other pairing, is an error.
- Out-of-range: any nonzero bit in addr[XLEN-1:DEPTH_LOG2+2] is an error.
- On error: no memory write, resp_err=1, resp_rdata=0, same latency as a normal request.
- Read-after-write to the same word in consecutive requests returns the new data (the write completes before the next acceptance).
- Reset mid-operation: FSM to IDLE and no pending write is performed; writes from already-completed access edges persist.
- req_* inputs are ignored whenever req_ready = 0.

Test Plan:
- LATENCY=2: store addr 0x10, wdata 0xDEADBEEF, amp 1111; then load addr 0x10 → load response has rdata 0xDEADBEEF, err 0; each resp_valid is high exactly one cycle, 2 cycles after acceptance.
- Byte-lane merge: word 0x10 = 0xDEADBEEF; store addr 0x12, wdata 0x00550000, amp 0100 → load 0x10 returns 0xDE55BEEF. Then store addr 0x10, wdata 0x0000AAAA, amp 0011 → load returns 0xDE55AAAA.
- Misaligned/illegal pattern: store addr 0x11, amp 0011 → err=1, rdata 0; then load 0x10 still returns 0xDE55AAAA. Repeat with amp 0101 → err=1.
- Out of range (DEPTH_LOG2=10): load addr 0x00001000 → err=1, rdata 0, normal latency.
- LATENCY=1, req_valid held high with 3 stores to 0x0/0x4/0x8 → req_ready stays 1, one resp_valid per cycle, then three loads read back all values.
- LATENCY=4: store 0x20 = 0x12345678, then assert reset 2 cycles after acceptance → no resp_valid and outputs are 0. After reset, load 0x20 returns the pre-test contents (initialized to 0 by the bench), not 0x12345678.
